textmem_arbiter: RTL and testbench

Shares the single text-memory port of the video driver (11-bit address, 16-bit char+attribute word, 1-cycle read) between the text editor and an internal clear/scroll engine. It sits between the editor and the video driver and owns the memory's address/data/write-enable lines. It executes whole-screen clear and one-line scroll-up commands autonomously, stalling the editor with a grant signal while the engine runs.

---
 rtl/textmem_pkg.sv | 22 ++
 rtl/textmem_engine.sv | 123 ++++++++++++
 rtl/textmem_arbiter.sv | 81 ++++++++
 tb/tb_textmem_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/textmem_pkg.sv
// rtl/textmem_pkg.sv - shared types and screen geometry for the text-memory arbiter
package textmem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_SCR_RD,
    S_SCR_WR,
    S_FILL,
    S_DONE
  } state_t;

  localparam int          DEF_COLS  = 80;
  localparam int          DEF_ROWS  = 25;
  localparam int          DEF_AW    = 11;
  localparam int          DEF_DW    = 16;
  localparam logic [15:0] DEF_BLANK = 16'h0720;

  localparam int SCREEN_WORDS  = DEF_COLS * DEF_ROWS;
  localparam int LAST_ROW_BASE = (DEF_ROWS - 1) * DEF_COLS;

endpackage

// File: rtl/textmem_engine.sv
// rtl/textmem_engine.sv - clear/scroll engine: pending flags, FSM, address counters
module textmem_engine
  import textmem_pkg::*;
#(
  parameter int          COLS  = DEF_COLS,
  parameter int          ROWS  = DEF_ROWS,
  parameter int          AW    = DEF_AW,
  parameter int          DW    = DEF_DW,
  parameter logic [DW-1:0] BLANK = DEF_BLANK
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic          cmd_clear,
  input  logic          cmd_scroll,
  input  logic [DW-1:0] ret_data,
  output logic          eng_hold,
  output logic [AW-1:0] eng_addr,
  output logic [DW-1:0] eng_data,
  output logic          eng_we,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] LAST_WORD    = AW'(COLS * ROWS - 1);
  localparam logic [AW-1:0] LAST_COPY    = AW'((ROWS - 1) * COLS - 1);
  localparam logic [AW-1:0] FILL_BASE    = AW'((ROWS - 1) * COLS);
  localparam logic [AW-1:0] SRC_BASE     = AW'(COLS);

  state_t        r_state;
  logic [AW-1:0] r_count;
  logic [AW-1:0] r_src;
  logic [AW-1:0] r_dst;
  logic          r_clr_p;
  logic          r_scr_p;
  logic          r_is_clr;

  // A same-cycle pulse is treated as already pending so the engine leaves IDLE at once.
  logic w_clr_req;
  logic w_scr_req;
  logic w_start_clr;
  logic w_fin_clr;
  logic w_fin_scr;

  assign w_clr_req   = r_clr_p | cmd_clear;
  assign w_scr_req   = r_scr_p | cmd_scroll;
  assign w_start_clr = (r_state == S_IDLE) & w_clr_req;
  assign w_fin_clr   = (r_state == S_DONE) & r_is_clr;
  assign w_fin_scr   = (r_state == S_DONE) & ~r_is_clr;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_src    <= '0;
      r_dst    <= '0;
      r_clr_p  <= 1'b0;
      r_scr_p  <= 1'b0;
      r_is_clr <= 1'b0;
    end else begin
      r_clr_p <= cmd_clear | (r_clr_p & ~w_fin_clr);
      r_scr_p <= ~w_start_clr & (cmd_scroll | (r_scr_p & ~w_fin_scr));
      case (r_state)
        S_IDLE: begin
          if (w_clr_req) begin
            r_state  <= S_CLR;
            r_count  <= '0;
            r_is_clr <= 1'b1;
          end else if (w_scr_req) begin
            r_state  <= S_SCR_RD;
            r_src    <= SRC_BASE;
            r_dst    <= '0;
            r_is_clr <= 1'b0;
          end
        end
        S_CLR, S_FILL: begin
          if (r_count == LAST_WORD) begin
            r_state <= S_DONE;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        S_SCR_RD: r_state <= S_SCR_WR;
        S_SCR_WR: begin
          r_src <= r_src + 1'b1;
          r_dst <= r_dst + 1'b1;
          if (r_dst == LAST_COPY) begin
            r_state <= S_FILL;
            r_count <= FILL_BASE;
          end else begin
            r_state <= S_SCR_RD;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    eng_addr = '0;
    eng_data = '0;
    eng_we   = 1'b0;
    case (r_state)
      S_CLR, S_FILL: begin
        eng_addr = r_count;
        eng_data = BLANK;
        eng_we   = 1'b1;
      end
      S_SCR_RD: eng_addr = r_src;
      S_SCR_WR: begin
        eng_addr = r_dst;
        eng_data = ret_data;
        eng_we   = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy     = (r_state != S_IDLE) | r_clr_p | r_scr_p;
  assign eng_hold = busy | cmd_clear | cmd_scroll;
  assign done     = (r_state == S_DONE);

endmodule

// File: rtl/textmem_arbiter.sv
// rtl/textmem_arbiter.sv - shares the video text-memory port between editor and clear/scroll engine
module textmem_arbiter
  import textmem_pkg::*;
#(
  parameter int          COLS  = DEF_COLS,
  parameter int          ROWS  = DEF_ROWS,
  parameter int          AW    = DEF_AW,
  parameter int          DW    = DEF_DW,
  parameter logic [DW-1:0] BLANK = DEF_BLANK
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic          ed_req,
  input  logic          ed_we,
  input  logic [AW-1:0] ed_addr,
  input  logic [DW-1:0] ed_wdata,
  output logic          ed_gnt,
  output logic [DW-1:0] ed_rdata,
  output logic          ed_rvalid,
  input  logic          cmd_clear,
  input  logic          cmd_scroll,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          we,
  input  logic [DW-1:0] ret_data
);

  logic          w_hold;
  logic [AW-1:0] w_eng_addr;
  logic [DW-1:0] w_eng_data;
  logic          w_eng_we;
  logic          r_rvalid;

  textmem_engine #(
    .COLS (COLS),
    .ROWS (ROWS),
    .AW   (AW),
    .DW   (DW),
    .BLANK(BLANK)
  ) u_engine (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .cmd_clear (cmd_clear),
    .cmd_scroll(cmd_scroll),
    .ret_data  (ret_data),
    .eng_hold  (w_hold),
    .eng_addr  (w_eng_addr),
    .eng_data  (w_eng_data),
    .eng_we    (w_eng_we),
    .busy      (busy),
    .done      (done)
  );

  // Grant is gated by reset so the port is quiet while reset is held.
  assign ed_gnt = rst_n & ed_req & ~w_hold;

  always_comb begin
    mem_addr = w_eng_addr;
    mem_data = w_eng_data;
    we       = w_eng_we;
    if (ed_gnt) begin
      mem_addr = ed_addr;
      mem_data = ed_wdata;
      we       = ed_we;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= ed_gnt & ~ed_we;
    end
  end

  assign ed_rvalid = r_rvalid;
  assign ed_rdata  = r_rvalid ? ret_data : '0;

endmodule

// File: tb/tb_textmem_arbiter.sv
// tb/tb_textmem_arbiter.sv - directed self-checking bench for textmem_arbiter
module tb_textmem_arbiter;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        ed_req;
  logic        ed_we;
  logic [10:0] ed_addr;
  logic [15:0] ed_wdata;
  logic        ed_gnt;
  logic [15:0] ed_rdata;
  logic        ed_rvalid;
  logic        cmd_clear;
  logic        cmd_scroll;
  logic        busy;
  logic        done;
  logic [10:0] mem_addr;
  logic [15:0] mem_data;
  logic        we;
  logic [15:0] ret_data;

  logic [15:0] mem [0:2047];
  logic        do_preload;
  int          high_writes;

  int n_checks = 0;
  int n_errors = 0;

  always #5 sys_clk = ~sys_clk;

  // Video-driver memory model: synchronous write, one-cycle read latency.
  always @(posedge sys_clk) begin
    if (do_preload) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 16'(i);
      high_writes <= 0;
    end else if (we) begin
      mem[mem_addr] <= mem_data;
      if (mem_addr >= 11'd2000) high_writes <= high_writes + 1;
    end
    ret_data <= mem[mem_addr];
  end

  textmem_arbiter dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .ed_req    (ed_req),
    .ed_we     (ed_we),
    .ed_addr   (ed_addr),
    .ed_wdata  (ed_wdata),
    .ed_gnt    (ed_gnt),
    .ed_rdata  (ed_rdata),
    .ed_rvalid (ed_rvalid),
    .cmd_clear (cmd_clear),
    .cmd_scroll(cmd_scroll),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .we        (we),
    .ret_data  (ret_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic preload();
    do_preload = 1'b1;
    step();
    do_preload = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"},    32'(ed_gnt),    32'd0);
    chk({tag, "_rvalid"}, 32'(ed_rvalid), 32'd0);
    chk({tag, "_rdata"},  32'(ed_rdata),  32'd0);
    chk({tag, "_done"},   32'(done),      32'd0);
    chk({tag, "_busy"},   32'(busy),      32'd0);
    chk({tag, "_we"},     32'(we),        32'd0);
    chk({tag, "_addr"},   32'(mem_addr),  32'd0);
    chk({tag, "_data"},   32'(mem_data),  32'd0);
  endtask

  // Runs until busy drops (bounded); scroll pulses may be injected at two sample indices.
  task automatic run_until_idle(input int limit, input int p1, input int p2,
                                output int bcnt, output int dcnt, output int gcnt);
    bcnt = 0;
    dcnt = 0;
    gcnt = 0;
    for (int k = 0; k < limit; k++) begin
      step();
      cmd_clear  = 1'b0;
      cmd_scroll = (k == p1) || (k == p2);
      if (!busy) break;
      bcnt++;
      if (done) dcnt++;
      if (ed_gnt) gcnt++;
    end
  endtask

  int bcnt, dcnt, gcnt, bad;

  initial begin
    rst_n = 1'b0; ed_req = 1'b0; ed_we = 1'b0; ed_addr = '0; ed_wdata = '0;
    cmd_clear = 1'b0; cmd_scroll = 1'b0; do_preload = 1'b0; high_writes = 0;
    preload();
    step();
    check_all_zero("reset");

    rst_n = 1'b1;
    step();
    cmd_clear = 1'b1;
    step();
    cmd_clear = 1'b0;
    for (int k = 0; k < 48; k++) step();
    chk("midclr_busy", 32'(busy), 32'd1);
    chk("midclr_we",   32'(we),   32'd1);
    rst_n = 1'b0;
    ed_req = 1'b1; ed_we = 1'b1; ed_addr = 11'd9; ed_wdata = 16'hBEEF;
    #1;
    check_all_zero("midrst");
    step();
    chk("midrst_partial_lo", 32'(mem[0]),    32'h0720);
    chk("midrst_partial_hi", 32'(mem[1999]), 32'd1999);
    rst_n = 1'b1;
    ed_req = 1'b0;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (done || busy) bad++;
    end
    chk("after_abort_quiet", 32'(bad), 32'd0);

    ed_req = 1'b1; ed_we = 1'b1; ed_addr = 11'd5; ed_wdata = 16'h1E41;
    #1;
    chk("wr_gnt",  32'(ed_gnt),   32'd1);
    chk("wr_we",   32'(we),       32'd1);
    chk("wr_addr", 32'(mem_addr), 32'd5);
    chk("wr_data", 32'(mem_data), 32'h1E41);
    step();
    chk("wr_stored", 32'(mem[5]), 32'h1E41);

    ed_we = 1'b0;
    #1;
    chk("rd_gnt", 32'(ed_gnt), 32'd1);
    chk("rd_we",  32'(we),     32'd0);
    step();
    ed_req = 1'b0;
    #1;
    chk("rd_rvalid", 32'(ed_rvalid), 32'd1);
    chk("rd_rdata",  32'(ed_rdata),  32'h1E41);
    step();
    chk("rd_rvalid_drop", 32'(ed_rvalid), 32'd0);

    preload();
    cmd_clear = 1'b1;
    run_until_idle(5000, -1, -1, bcnt, dcnt, gcnt);
    chk("clr_busy_cycles", 32'(bcnt), 32'd2001);
    chk("clr_done_pulses", 32'(dcnt), 32'd1);
    bad = 0;
    for (int i = 0; i < 2000; i++) if (mem[i] !== 16'h0720) bad++;
    chk("clr_words_blank", 32'(bad), 32'd0);
    chk("clr_no_high_writes", 32'(high_writes), 32'd0);
    chk("clr_word2000_kept", 32'(mem[2000]), 32'd2000);

    preload();
    cmd_scroll = 1'b1;
    run_until_idle(6000, -1, -1, bcnt, dcnt, gcnt);
    chk("scr_busy_cycles", 32'(bcnt), 32'd3921);
    chk("scr_done_pulses", 32'(dcnt), 32'd1);
    bad = 0;
    for (int i = 0; i < 1920; i++) if (mem[i] !== 16'(i + 80)) bad++;
    chk("scr_words_shifted", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 1920; i < 2000; i++) if (mem[i] !== 16'h0720) bad++;
    chk("scr_last_row_blank", 32'(bad), 32'd0);
    chk("scr_no_high_writes", 32'(high_writes), 32'd0);

    preload();
    ed_req = 1'b1; ed_we = 1'b1; ed_addr = 11'd7; ed_wdata = 16'h1234;
    cmd_clear = 1'b1; cmd_scroll = 1'b1;
    #1;
    chk("both_pulse_gnt", 32'(ed_gnt), 32'd0);
    run_until_idle(8000, -1, -1, bcnt, dcnt, gcnt);
    chk("both_busy_cycles", 32'(bcnt), 32'd2001);
    chk("both_done_pulses", 32'(dcnt), 32'd1);
    chk("both_gnt_while_busy", 32'(gcnt), 32'd0);
    chk("both_gnt_after", 32'(ed_gnt), 32'd1);
    step();
    ed_req = 1'b0;
    chk("both_editor_write", 32'(mem[7]), 32'h1234);
    chk("both_clear_ran", 32'(mem[100]), 32'h0720);

    preload();
    cmd_clear = 1'b1;
    run_until_idle(8000, 10, 20, bcnt, dcnt, gcnt);
    chk("chain_busy_cycles", 32'(bcnt), 32'd5923);
    chk("chain_done_pulses", 32'(dcnt), 32'd2);
    bad = 0;
    for (int i = 0; i < 2000; i++) if (mem[i] !== 16'h0720) bad++;
    chk("chain_words_blank", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
